event_streamer: RTL and testbench
=================================

EVENT_STREAMER -- requirements
Module: event_streamer

Interface
REQ-001 Parameter WORDS_PER_EVENT, default 16: data words per event packet read from the event FIFO.
REQ-002 Parameter DATA_W, default 64: FIFO and stream data width.
REQ-003 clk  in  1  system clock; all logic on rising edge.
REQ-004 aresetn  in  1  reset, asynchronous, active-low.
REQ-005 enable_i  in  1  permits starting a new packet.
REQ-006 timestamp_i  in  32  free-running time counter, sampled into the header.
REQ-007 fifo_dout_i  in  DATA_W  event FIFO read data, valid exactly 1 cycle after fifo_rd_en_o (standard, non-FWFT).
REQ-008 fifo_empty_i  in  1  event FIFO empty flag.
REQ-009 fifo_rd_en_o  out  1  event FIFO read strobe.
REQ-010 m_axis_tdata  out  DATA_W  AXI4-Stream data.
REQ-011 m_axis_tvalid  out  1  AXI4-Stream valid.
REQ-012 m_axis_tready  in  1  AXI4-Stream ready.
REQ-013 m_axis_tlast  out  1  marks last beat of a packet.
REQ-014 m_axis_tkeep  out  DATA_W/8  byte enables; all ones whenever tvalid=1.
REQ-015 packet_done_o  out  1  one-cycle pulse after a packet's last beat is accepted.
REQ-016 event_count_o  out  32  number of completed packets since reset.

Function
REQ-017 FSM states IDLE, HEADER, STREAM, DONE shall exist; reset state IDLE.
REQ-018 IDLE -> HEADER when enable_i=1 and fifo_empty_i=0; on this transition timestamp_i and event_count_o are latched into the header register.
REQ-019 HEADER: tvalid=1, tdata={latched event_count[31:0], latched timestamp[31:0]}, tlast=0; HEADER -> STREAM on tvalid&&tready.
REQ-020 STREAM: exactly WORDS_PER_EVENT FIFO words are read and forwarded in FIFO order, unmodified.
REQ-021 Data path: 2-entry output buffer (occupancy occ 0..2) plus in-flight flag inf (0..1) for the read issued last cycle.
REQ-022 fifo_rd_en_o=1 only when state=STREAM, fifo_empty_i=0, issued count < WORDS_PER_EVENT, and occ+inf-pop < 2, where pop = data-beat handshake this cycle.
REQ-023 fifo_rd_en_o shall never be asserted while fifo_empty_i=1 nor more than WORDS_PER_EVENT times per packet.
REQ-024 Word returned on fifo_dout_i the cycle after a read enters the buffer tail; tvalid=1 whenever occ>0 in STREAM; tdata = buffer head.
REQ-025 With tready held 1 and FIFO non-empty, sustained throughput shall be one data beat per cycle; first data beat appears 2 cycles after the header handshake.
REQ-026 tlast=1 on the WORDS_PER_EVENT-th data beat only; STREAM -> DONE on its handshake.
REQ-027 tvalid, once asserted, shall stay asserted with tdata/tlast stable until tready=1 (AXI-Stream rule).
REQ-028 tready=0 shall stall output without loss or duplication; reads stop when buffer full.
REQ-029 FIFO empty mid-packet: block waits in STREAM, no timeout, tvalid drops when occ=0, resumes on refill.
REQ-030 DONE: packet_done_o=1 for one cycle, event_count_o increments by 1 (wraps 0xFFFFFFFF -> 0), -> IDLE.
REQ-031 enable_i deassertion mid-packet shall not abort; current packet completes, no new packet starts.
REQ-032 Back-to-back: with enable_i=1 and FIFO non-empty, HEADER follows DONE->IDLE with no other idle cycles.

Reset
REQ-033 On aresetn=0 (any state, including mid-packet): state=IDLE, occ=0, inf=0, counters=0, fifo_rd_en_o=0, m_axis_tvalid=0, tlast=0, tdata=0, packet_done_o=0, event_count_o=0.
REQ-034 Words already consumed from the FIFO are discarded on reset; the FIFO itself is flushed externally.

Verification
REQ-035 FIFO preloaded with 16 words 0x1..0x10, timestamp_i=0x100 at start, tready=1 -> header 0x0000_0000_0000_0100, then 0x1..0x10 on consecutive cycles, tlast on 0x10, packet_done_o pulse, event_count_o=1.
REQ-036 Same stimulus, tready toggling 1/0 every cycle -> identical 17-beat sequence, no duplicates, tdata stable during stalls.
REQ-037 FIFO holds 8 words, remaining 8 written 20 cycles later -> tvalid gaps, no rd_en while empty, 16 correct data beats, single tlast.
REQ-038 Two events (32 words) preloaded, enable_i=1 -> two packets, second header event_count field=1, event_count_o=2.
REQ-039 aresetn pulsed low after 5th data beat -> all outputs zero next cycle; after release, idle until FIFO non-empty and enable_i=1.
REQ-040 enable_i=0 with FIFO non-empty -> no rd_en, no tvalid; dropped mid-packet -> packet completes, no second header.

Source files
------------

// File: rtl/event_streamer.sv
// Event packet streamer: reads fixed-size events from a standard (non-FWFT) FIFO
// and emits them on AXI4-Stream, each preceded by a {event_count, timestamp} header.
module event_streamer #(
  parameter int unsigned WORDS_PER_EVENT = 16,
  parameter int unsigned DATA_W          = 64
) (
  input  logic                clk,
  input  logic                aresetn,
  input  logic                enable_i,
  input  logic [31:0]         timestamp_i,
  input  logic [DATA_W-1:0]   fifo_dout_i,
  input  logic                fifo_empty_i,
  output logic                fifo_rd_en_o,
  output logic [DATA_W-1:0]   m_axis_tdata,
  output logic                m_axis_tvalid,
  input  logic                m_axis_tready,
  output logic                m_axis_tlast,
  output logic [DATA_W/8-1:0] m_axis_tkeep,
  output logic                packet_done_o,
  output logic [31:0]         event_count_o
);

  localparam int unsigned CntW  = $clog2(WORDS_PER_EVENT + 1);
  localparam int unsigned KeepW = DATA_W / 8;

  typedef enum logic [1:0] {StIdle, StHeader, StStream, StDone} state_e;

  state_e              state_q, state_d;
  logic [63:0]         hdr_q, hdr_d;
  logic [DATA_W-1:0]   buf_q [2];
  logic [DATA_W-1:0]   buf_d [2];
  logic [1:0]          occ_q, occ_d;
  logic                inf_q, inf_d;
  logic [CntW-1:0]     issued_q, issued_d;
  logic [CntW-1:0]     beats_q, beats_d;
  logic [31:0]         count_q, count_d;

  logic                pop;
  logic                rd_en;
  logic                last_beat;
  logic [2:0]          fill_after_pop;
  logic [1:0]          occ_tmp;

  // Read-issue control: pop frees a slot this cycle, so it counts towards room for a new read.
  always_comb begin
    pop            = (state_q == StStream) && (occ_q != 2'd0) && m_axis_tready;
    // pop implies occ_q > 0, so this never underflows
    fill_after_pop = {1'b0, occ_q} + {2'b00, inf_q} - {2'b00, pop};
    rd_en          = (state_q == StStream) && !fifo_empty_i &&
                     (issued_q < CntW'(WORDS_PER_EVENT)) && (fill_after_pop < 3'd2);
    last_beat      = (beats_q == CntW'(WORDS_PER_EVENT - 1));
  end

  // Two-entry output buffer: head shifts out on pop, returning read data lands at the tail.
  always_comb begin
    buf_d   = buf_q;
    occ_tmp = occ_q;
    if (pop) begin
      buf_d[0] = buf_q[1];
      occ_tmp  = occ_q - 2'd1;
    end
    // occ_tmp is 0 or 1 whenever a read is in flight, so bit 0 selects the free slot
    if (inf_q) begin
      buf_d[occ_tmp[0]] = fifo_dout_i;
    end
    occ_d = occ_tmp + {1'b0, inf_q};
    inf_d = rd_en;
  end

  // Packet FSM next-state and stream outputs.
  always_comb begin
    state_d       = state_q;
    hdr_d         = hdr_q;
    count_d       = count_q;
    issued_d      = issued_q;
    beats_d       = beats_q;
    packet_done_o = 1'b0;
    m_axis_tvalid = 1'b0;
    m_axis_tlast  = 1'b0;
    m_axis_tdata  = '0;
    unique case (state_q)
      StIdle: begin
        if (enable_i && !fifo_empty_i) begin
          hdr_d   = {count_q, timestamp_i};
          state_d = StHeader;
        end
      end
      StHeader: begin
        m_axis_tvalid = 1'b1;
        m_axis_tdata  = DATA_W'(hdr_q);
        issued_d      = '0;
        beats_d       = '0;
        if (m_axis_tready) begin
          state_d = StStream;
        end
      end
      StStream: begin
        m_axis_tvalid = (occ_q != 2'd0);
        if (occ_q != 2'd0) begin
          m_axis_tdata = buf_q[0];
          m_axis_tlast = last_beat;
        end
        issued_d = issued_q + CntW'(rd_en);
        beats_d  = beats_q + CntW'(pop);
        if (pop && last_beat) begin
          state_d = StDone;
        end
      end
      StDone: begin
        packet_done_o = 1'b1;
        count_d       = count_q + 32'd1;
        state_d       = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    fifo_rd_en_o  = rd_en;
    event_count_o = count_q;
    m_axis_tkeep  = m_axis_tvalid ? {KeepW{1'b1}} : {KeepW{1'b0}};
  end

  // State registers; reset discards any buffered or in-flight words.
  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      state_q  <= StIdle;
      hdr_q    <= '0;
      buf_q[0] <= '0;
      buf_q[1] <= '0;
      occ_q    <= '0;
      inf_q    <= 1'b0;
      issued_q <= '0;
      beats_q  <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      hdr_q    <= hdr_d;
      buf_q    <= buf_d;
      occ_q    <= occ_d;
      inf_q    <= inf_d;
      issued_q <= issued_d;
      beats_q  <= beats_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: tb/tb_event_streamer.sv
// Directed bench for event_streamer with a cycle-level non-FWFT FIFO model.
module tb_event_streamer;

  logic        clk = 1'b0;
  logic        aresetn = 1'b0;
  logic        enable_i = 1'b0;
  logic [31:0] timestamp_i = 32'h100;
  logic [63:0] fifo_dout_i = '0;
  logic        fifo_empty_i = 1'b1;
  logic        fifo_rd_en_o;
  logic [63:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready = 1'b0;
  logic        m_axis_tlast;
  logic [7:0]  m_axis_tkeep;
  logic        packet_done_o;
  logic [31:0] event_count_o;

  int n_checks = 0;
  int n_errors = 0;

  logic [63:0] fq[$];
  logic [63:0] obs_data[$];
  logic        obs_last[$];
  int          obs_cyc[$];
  logic [63:0] exp_q[$];

  int cyc = 0;
  int done_cnt, done_cyc, first_done_cyc, rd_cnt, rd_empty_cnt;
  int stall_bad, stall_cnt, keep_bad, gap_cnt, valid_cnt;
  bit toggle_ready = 1'b0;
  bit stall_q = 1'b0;
  logic [63:0] stall_data;
  logic        stall_last;
  bit ok;

  event_streamer #(
    .WORDS_PER_EVENT(16),
    .DATA_W         (64)
  ) dut (
    .clk          (clk),
    .aresetn      (aresetn),
    .enable_i     (enable_i),
    .timestamp_i  (timestamp_i),
    .fifo_dout_i  (fifo_dout_i),
    .fifo_empty_i (fifo_empty_i),
    .fifo_rd_en_o (fifo_rd_en_o),
    .m_axis_tdata (m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready),
    .m_axis_tlast (m_axis_tlast),
    .m_axis_tkeep (m_axis_tkeep),
    .packet_done_o(packet_done_o),
    .event_count_o(event_count_o)
  );

  always #5 clk = ~clk;

  task automatic clear_obs();
    obs_data.delete();
    obs_last.delete();
    obs_cyc.delete();
    exp_q.delete();
    done_cnt = 0; done_cyc = 0; first_done_cyc = 0; rd_cnt = 0; rd_empty_cnt = 0;
    stall_bad = 0; stall_cnt = 0; keep_bad = 0; gap_cnt = 0; valid_cnt = 0;
    stall_q = 1'b0;
  endtask

  task automatic push_words(input logic [63:0] base, input int n);
    for (int i = 0; i < n; i++) fq.push_back(base + 64'(i));
    fifo_empty_i = (fq.size() == 0);
  endtask

  // One clock: capture the read strobe, update the FIFO model, then record outputs at negedge.
  task automatic tick();
    logic rd;
    #1;
    rd = fifo_rd_en_o;
    if (rd) rd_cnt++;
    if (rd && fifo_empty_i) rd_empty_cnt++;
    @(posedge clk);
    #1;
    cyc++;
    if (rd && fq.size() > 0) fifo_dout_i = fq.pop_front();
    if (toggle_ready) m_axis_tready = ~m_axis_tready;
    fifo_empty_i = (fq.size() == 0);
    @(negedge clk);
    if (stall_q && !(m_axis_tvalid && m_axis_tdata == stall_data && m_axis_tlast == stall_last))
      stall_bad++;
    if (m_axis_tvalid) valid_cnt++;
    if (m_axis_tvalid && m_axis_tkeep != 8'hFF) keep_bad++;
    if (!m_axis_tvalid && obs_data.size() >= 2 && obs_data.size() < 17) gap_cnt++;
    if (m_axis_tvalid && m_axis_tready) begin
      obs_data.push_back(m_axis_tdata);
      obs_last.push_back(m_axis_tlast);
      obs_cyc.push_back(cyc);
    end
    stall_q    = m_axis_tvalid && !m_axis_tready;
    if (stall_q) stall_cnt++;
    stall_data = m_axis_tdata;
    stall_last = m_axis_tlast;
    if (packet_done_o) begin
      done_cnt++;
      done_cyc = cyc;
      if (done_cnt == 1) first_done_cyc = cyc;
    end
  endtask

  task automatic run_until_done(input int target, input int budget, output bit fin);
    int k = 0;
    while (done_cnt < target && k < budget) begin
      tick();
      k++;
    end
    fin = (done_cnt >= target);
  endtask

  task automatic test_reset();
    aresetn = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0 || m_axis_tdata !== 64'h0)
      begin n_errors++; $display("FAIL reset_stream: valid=%b last=%b data=%h required 0/0/0",
        m_axis_tvalid, m_axis_tlast, m_axis_tdata); end
    n_checks++;
    if (fifo_rd_en_o !== 1'b0 || packet_done_o !== 1'b0 || event_count_o !== 32'h0)
      begin n_errors++; $display("FAIL reset_ctrl: rd=%b done=%b count=%h required 0/0/0",
        fifo_rd_en_o, packet_done_o, event_count_o); end
    aresetn = 1'b1;
    clear_obs();
    repeat (3) tick();
    n_checks++;
    if (valid_cnt != 0 || rd_cnt != 0)
      begin n_errors++; $display("FAIL reset_idle: valid_cycles=%0d reads=%0d required 0/0",
        valid_cnt, rd_cnt); end
  endtask

  task automatic test_basic();
    clear_obs();
    push_words(64'h1, 16);
    m_axis_tready = 1'b1;
    enable_i = 1'b1;
    run_until_done(1, 100, ok);
    enable_i = 1'b0;
    repeat (5) tick();
    n_checks++;
    if (!ok) begin n_errors++; $display("FAIL basic_timeout: packet_done not seen"); end
    exp_q.push_back(64'h0000_0000_0000_0100);
    for (int i = 1; i <= 16; i++) exp_q.push_back(64'(i));
    n_checks++;
    if (obs_data.size() != 17)
      begin n_errors++; $display("FAIL basic_beats: got %0d required 17", obs_data.size()); end
    for (int i = 0; i < 17 && i < obs_data.size(); i++) begin
      n_checks++;
      if (obs_data[i] !== exp_q[i] || obs_last[i] !== (i == 16))
        begin n_errors++; $display("FAIL basic_beat[%0d]: got %h/%b required %h/%b",
          i, obs_data[i], obs_last[i], exp_q[i], (i == 16)); end
    end
    for (int i = 2; i < 17 && i < obs_cyc.size(); i++) begin
      n_checks++;
      if (obs_cyc[i] - obs_cyc[i-1] != 1)
        begin n_errors++; $display("FAIL basic_throughput[%0d]: gap %0d required 1",
          i, obs_cyc[i] - obs_cyc[i-1]); end
    end
    n_checks++;
    if (event_count_o !== 32'd1 || done_cnt != 1)
      begin n_errors++; $display("FAIL basic_count: count=%0d pulses=%0d required 1/1",
        event_count_o, done_cnt); end
    n_checks++;
    if (rd_cnt != 16 || rd_empty_cnt != 0 || keep_bad != 0)
      begin n_errors++; $display("FAIL basic_reads: reads=%0d empty_reads=%0d keep_bad=%0d required 16/0/0",
        rd_cnt, rd_empty_cnt, keep_bad); end
  endtask

  task automatic test_stall();
    clear_obs();
    push_words(64'h1, 16);
    m_axis_tready = 1'b1;
    toggle_ready = 1'b1;
    enable_i = 1'b1;
    run_until_done(1, 200, ok);
    enable_i = 1'b0;
    toggle_ready = 1'b0;
    m_axis_tready = 1'b1;
    repeat (5) tick();
    n_checks++;
    if (!ok) begin n_errors++; $display("FAIL stall_timeout: packet_done not seen"); end
    exp_q.push_back(64'h0000_0001_0000_0100);
    for (int i = 1; i <= 16; i++) exp_q.push_back(64'(i));
    n_checks++;
    if (obs_data.size() != 17)
      begin n_errors++; $display("FAIL stall_beats: got %0d required 17", obs_data.size()); end
    for (int i = 0; i < 17 && i < obs_data.size(); i++) begin
      n_checks++;
      if (obs_data[i] !== exp_q[i] || obs_last[i] !== (i == 16))
        begin n_errors++; $display("FAIL stall_beat[%0d]: got %h/%b required %h/%b",
          i, obs_data[i], obs_last[i], exp_q[i], (i == 16)); end
    end
    n_checks++;
    if (stall_bad != 0 || stall_cnt == 0)
      begin n_errors++; $display("FAIL stall_stable: unstable=%0d stalls=%0d required 0/>0",
        stall_bad, stall_cnt); end
    n_checks++;
    if (event_count_o !== 32'd2 || rd_cnt != 16)
      begin n_errors++; $display("FAIL stall_count: count=%0d reads=%0d required 2/16",
        event_count_o, rd_cnt); end
  endtask

  task automatic test_empty_gap();
    clear_obs();
    push_words(64'h1, 8);
    m_axis_tready = 1'b1;
    enable_i = 1'b1;
    repeat (20) tick();
    push_words(64'h9, 8);
    run_until_done(1, 100, ok);
    enable_i = 1'b0;
    repeat (5) tick();
    n_checks++;
    if (!ok) begin n_errors++; $display("FAIL gap_timeout: packet_done not seen"); end
    exp_q.push_back(64'h0000_0002_0000_0100);
    for (int i = 1; i <= 16; i++) exp_q.push_back(64'(i));
    n_checks++;
    if (obs_data.size() != 17)
      begin n_errors++; $display("FAIL gap_beats: got %0d required 17", obs_data.size()); end
    for (int i = 0; i < 17 && i < obs_data.size(); i++) begin
      n_checks++;
      if (obs_data[i] !== exp_q[i] || obs_last[i] !== (i == 16))
        begin n_errors++; $display("FAIL gap_beat[%0d]: got %h/%b required %h/%b",
          i, obs_data[i], obs_last[i], exp_q[i], (i == 16)); end
    end
    n_checks++;
    if (gap_cnt == 0 || rd_empty_cnt != 0 || rd_cnt != 16)
      begin n_errors++; $display("FAIL gap_reads: gaps=%0d empty_reads=%0d reads=%0d required >0/0/16",
        gap_cnt, rd_empty_cnt, rd_cnt); end
    n_checks++;
    if (event_count_o !== 32'd3)
      begin n_errors++; $display("FAIL gap_count: got %0d required 3", event_count_o); end
  endtask

  task automatic test_back_to_back();
    clear_obs();
    push_words(64'h1, 32);
    m_axis_tready = 1'b1;
    enable_i = 1'b1;
    run_until_done(2, 200, ok);
    enable_i = 1'b0;
    repeat (5) tick();
    n_checks++;
    if (!ok) begin n_errors++; $display("FAIL b2b_timeout: %0d packets done required 2", done_cnt); end
    exp_q.push_back(64'h0000_0003_0000_0100);
    for (int i = 1; i <= 16; i++) exp_q.push_back(64'(i));
    exp_q.push_back(64'h0000_0004_0000_0100);
    for (int i = 17; i <= 32; i++) exp_q.push_back(64'(i));
    n_checks++;
    if (obs_data.size() != 34)
      begin n_errors++; $display("FAIL b2b_beats: got %0d required 34", obs_data.size()); end
    for (int i = 0; i < 34 && i < obs_data.size(); i++) begin
      n_checks++;
      if (obs_data[i] !== exp_q[i] || obs_last[i] !== (i == 16 || i == 33))
        begin n_errors++; $display("FAIL b2b_beat[%0d]: got %h/%b required %h/%b",
          i, obs_data[i], obs_last[i], exp_q[i], (i == 16 || i == 33)); end
    end
    if (obs_cyc.size() > 17) begin
      n_checks++;
      if (obs_cyc[17] != first_done_cyc + 2)
        begin n_errors++; $display("FAIL b2b_turnaround: header at %0d required %0d",
          obs_cyc[17], first_done_cyc + 2); end
    end
    n_checks++;
    if (event_count_o !== 32'd5 || done_cnt != 2)
      begin n_errors++; $display("FAIL b2b_count: count=%0d pulses=%0d required 5/2",
        event_count_o, done_cnt); end
  endtask

  task automatic test_enable();
    int k;
    clear_obs();
    enable_i = 1'b0;
    m_axis_tready = 1'b1;
    push_words(64'h41, 32);
    repeat (10) tick();
    n_checks++;
    if (rd_cnt != 0 || valid_cnt != 0)
      begin n_errors++; $display("FAIL enable_off: reads=%0d valid_cycles=%0d required 0/0",
        rd_cnt, valid_cnt); end
    enable_i = 1'b1;
    k = 0;
    while (obs_data.size() < 4 && k < 30) begin tick(); k++; end
    enable_i = 1'b0;
    run_until_done(1, 100, ok);
    repeat (20) tick();
    n_checks++;
    if (!ok) begin n_errors++; $display("FAIL enable_timeout: packet_done not seen"); end
    exp_q.push_back(64'h0000_0005_0000_0100);
    for (int i = 0; i < 16; i++) exp_q.push_back(64'h41 + 64'(i));
    n_checks++;
    if (obs_data.size() != 17)
      begin n_errors++; $display("FAIL enable_beats: got %0d required 17", obs_data.size()); end
    for (int i = 0; i < 17 && i < obs_data.size(); i++) begin
      n_checks++;
      if (obs_data[i] !== exp_q[i])
        begin n_errors++; $display("FAIL enable_beat[%0d]: got %h required %h",
          i, obs_data[i], exp_q[i]); end
    end
    n_checks++;
    if (event_count_o !== 32'd6 || fq.size() != 16 || done_cnt != 1)
      begin n_errors++; $display("FAIL enable_stop: count=%0d fifo_left=%0d pulses=%0d required 6/16/1",
        event_count_o, fq.size(), done_cnt); end
  endtask

  task automatic test_reset_mid();
    int k;
    clear_obs();
    m_axis_tready = 1'b1;
    enable_i = 1'b1;
    k = 0;
    while (obs_data.size() < 6 && k < 40) begin tick(); k++; end
    n_checks++;
    if (obs_data.size() < 6 || obs_data[5] !== 64'h55)
      begin n_errors++; $display("FAIL rstmid_pre: beats=%0d required 6 ending in 55",
        obs_data.size()); end
    aresetn = 1'b0;
    #1;
    n_checks++;
    if (m_axis_tvalid !== 1'b0 || m_axis_tlast !== 1'b0 || m_axis_tdata !== 64'h0 ||
        fifo_rd_en_o !== 1'b0 || packet_done_o !== 1'b0 || event_count_o !== 32'h0)
      begin n_errors++; $display("FAIL rstmid_outputs: valid=%b last=%b data=%h rd=%b done=%b count=%h required all 0",
        m_axis_tvalid, m_axis_tlast, m_axis_tdata, fifo_rd_en_o, packet_done_o, event_count_o); end
    fq.delete();
    fifo_empty_i = 1'b1;
    repeat (2) tick();
    aresetn = 1'b1;
    clear_obs();
    repeat (5) tick();
    n_checks++;
    if (valid_cnt != 0 || rd_cnt != 0)
      begin n_errors++; $display("FAIL rstmid_idle: valid_cycles=%0d reads=%0d required 0/0",
        valid_cnt, rd_cnt); end
    push_words(64'h71, 16);
    run_until_done(1, 100, ok);
    enable_i = 1'b0;
    repeat (3) tick();
    n_checks++;
    if (!ok) begin n_errors++; $display("FAIL rstmid_timeout: packet_done not seen"); end
    exp_q.push_back(64'h0000_0000_0000_0100);
    for (int i = 0; i < 16; i++) exp_q.push_back(64'h71 + 64'(i));
    n_checks++;
    if (obs_data.size() != 17)
      begin n_errors++; $display("FAIL rstmid_beats: got %0d required 17", obs_data.size()); end
    for (int i = 0; i < 17 && i < obs_data.size(); i++) begin
      n_checks++;
      if (obs_data[i] !== exp_q[i] || obs_last[i] !== (i == 16))
        begin n_errors++; $display("FAIL rstmid_beat[%0d]: got %h/%b required %h/%b",
          i, obs_data[i], obs_last[i], exp_q[i], (i == 16)); end
    end
    n_checks++;
    if (event_count_o !== 32'd1)
      begin n_errors++; $display("FAIL rstmid_count: got %0d required 1", event_count_o); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_stall();
    test_empty_gap();
    test_back_to_back();
    test_enable();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

endmodule
